booth_free_mult8: RTL and testbench



---
 rtl/mult_pkg.sv | 19 +
 rtl/add_sub9.sv | 39 +++
 rtl/booth_free_mult8.sv | 104 ++++++++++
 tb/tb_booth_free_mult8.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential add-shift signed multiplier.
package mult_pkg;

    // Default operand width; must be a multiple of 4 to match the adder slices.
    localparam int MULT_WIDTH = 8;
    localparam int MULT_CNT_W = $clog2(MULT_WIDTH);

    // Iteration counter type for the default width.
    typedef logic [MULT_CNT_W-1:0] count_t;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADD   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/add_sub9.sv
// Sign-extending W+1 bit add/subtract built from 4-bit carry-select slices
// plus a 1-bit top stage producing the sign of the exact result.
module add_sub9 #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] s,
    input  logic         sub,
    output logic [W:0]   sum
);

    localparam int NSL = W / 4;

    logic [W-1:0] w_s_eff;
    logic [NSL:0] w_carry;

    // Subtraction is a + ~s + 1: invert s here and feed sub as the first carry-in.
    assign w_s_eff    = s ^ {W{sub}};
    assign w_carry[0] = sub;

    genvar gi;
    generate
        for (gi = 0; gi < NSL; gi = gi + 1) begin : g_slice
            logic [4:0] w_sum0;
            logic [4:0] w_sum1;

            // Both carry-in outcomes are precomputed; the incoming carry only selects.
            assign w_sum0 = {1'b0, a[gi*4 +: 4]} + {1'b0, w_s_eff[gi*4 +: 4]};
            assign w_sum1 = {1'b0, a[gi*4 +: 4]} + {1'b0, w_s_eff[gi*4 +: 4]} + 5'd1;

            assign sum[gi*4 +: 4] = w_carry[gi] ? w_sum1[3:0] : w_sum0[3:0];
            assign w_carry[gi+1]  = w_carry[gi] ? w_sum1[4]   : w_sum0[4];
        end
    endgenerate

    // Top stage adds the sign-extension bits of both operands so the result is exact.
    assign sum[W] = a[W-1] ^ w_s_eff[W-1] ^ w_carry[NSL];

endmodule

// File: rtl/booth_free_mult8.sv
// Sequential add-shift two's complement multiplier: one ADD and one SHIFT
// cycle per multiplier bit, final iteration subtracts. Product in {aval, bval}.
module booth_free_mult8 import mult_pkg::*; #(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             run,
    input  logic             clra_ldb,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] aval,
    output logic [WIDTH-1:0] bval,
    output logic             x,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_x;
    logic [CNT_W-1:0] r_count;
    logic             r_busy;
    logic             r_done;

    logic             w_sub;
    logic [WIDTH:0]   w_sum;

    // The multiplier's top bit carries negative weight, so its partial product is subtracted.
    assign w_sub = (r_count == LAST_ITER);

    add_sub9 #(
        .W (WIDTH)
    ) u_add_sub (
        .a   (r_a),
        .s   (r_s),
        .sub (w_sub),
        .sum (w_sum)
    );

    // Controller and datapath registers; busy/done are registered from the current state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_x     <= 1'b0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_busy <= (r_state == ST_ADD) || (r_state == ST_SHIFT);
            r_done <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (clra_ldb) begin
                        r_a <= '0;
                        r_x <= 1'b0;
                        r_b <= sw;
                    end else if (run) begin
                        r_a     <= '0;
                        r_x     <= 1'b0;
                        r_s     <= sw;
                        r_count <= '0;
                        r_state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    if (r_b[0]) begin
                        {r_x, r_a} <= w_sum;
                    end
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    r_a     <= {r_x, r_a[WIDTH-1:1]};
                    r_b     <= {r_a[0], r_b[WIDTH-1:1]};
                    r_count <= r_count + CNT_W'(1);
                    r_state <= (r_count == LAST_ITER) ? ST_DONE : ST_ADD;
                end
                ST_DONE: begin
                    // No auto-restart: run must drop before another multiply can begin.
                    if (!run) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign aval = r_a;
    assign bval = r_b;
    assign x    = r_x;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_booth_free_mult8.sv
// Self-checking bench for booth_free_mult8: directed cases plus random
// operand pairs compared against plain signed integer multiplication.
module tb_booth_free_mult8;

    logic       Clk;
    logic       Reset;
    logic       run;
    logic       clra_ldb;
    logic [7:0] sw;
    logic [7:0] aval;
    logic [7:0] bval;
    logic       x;
    logic       busy;
    logic       done;

    int total;
    int bad;

    booth_free_mult8 #(
        .WIDTH (8)
    ) u_dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .run      (run),
        .clra_ldb (clra_ldb),
        .sw       (sw),
        .aval     (aval),
        .bval     (bval),
        .x        (x),
        .busy     (busy),
        .done     (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic load_b(input logic [7:0] bv);
        @(negedge Clk);
        clra_ldb = 1'b1;
        sw       = bv;
        @(negedge Clk);
        clra_ldb = 1'b0;
    endtask

    // Runs one multiply with B already loaded as bv; checks timing and product.
    task automatic mult_and_check(input string tag, input logic [7:0] bv, input logic [7:0] sv,
                                  input bit hold, input bit clr_busy);
        int          p;
        logic [31:0] pv;
        int          lat;
        int          bcnt;
        p  = int'($signed(bv)) * int'($signed(sv));
        pv = p;
        @(negedge Clk);
        sw  = sv;
        run = 1'b1;
        @(posedge Clk);
        #1;
        if (!hold) run = 1'b0;
        lat  = 0;
        bcnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge Clk);
            #1;
            if (clr_busy && i == 1) begin
                clra_ldb = 1'b1;
                sw       = 8'hAA;
            end
            if (clr_busy && i == 12) clra_ldb = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                lat = i;
                break;
            end
        end
        clra_ldb = 1'b0;
        check_val({tag, "_latency"}, lat, 17);
        check_val({tag, "_busy_cycles"}, bcnt, 16);
        check_val({tag, "_aval"}, {24'd0, aval}, {24'd0, pv[15:8]});
        check_val({tag, "_bval"}, {24'd0, bval}, {24'd0, pv[7:0]});
        check_val({tag, "_x"}, {31'd0, x}, {31'd0, (p < 0)});
        $display("mult %s: b=%02h s=%02h -> x=%0b aval=%02h bval=%02h (lat %0d)",
                 tag, bv, sv, x, aval, bval, lat);
    endtask

    initial begin
        logic [7:0] held_a;
        logic [7:0] held_b;
        logic [7:0] rb;
        logic [7:0] rs;
        total    = 0;
        bad      = 0;
        Reset    = 1'b1;
        run      = 1'b0;
        clra_ldb = 1'b0;
        sw       = 8'h00;
        repeat (2) @(posedge Clk);
        #1;
        check_val("rst_aval", {24'd0, aval}, 32'd0);
        check_val("rst_bval", {24'd0, bval}, 32'd0);
        check_val("rst_x", {31'd0, x}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // Directed cases
        load_b(8'h03);
        mult_and_check("3x7", 8'h03, 8'h07, 1'b0, 1'b0);
        load_b(8'h03);
        mult_and_check("3xm7", 8'h03, 8'hF9, 1'b0, 1'b0);
        load_b(8'hF9);
        mult_and_check("m7x3", 8'hF9, 8'h03, 1'b0, 1'b0);
        load_b(8'h80);
        mult_and_check("m128sq", 8'h80, 8'h80, 1'b0, 1'b0);
        load_b(8'h7F);
        mult_and_check("127sq", 8'h7F, 8'h7F, 1'b0, 1'b0);

        // clra_ldb and sw activity during a multiply must not disturb B or S
        load_b(8'h05);
        mult_and_check("clr_busy", 8'h05, 8'h03, 1'b0, 1'b1);

        // Reset in the middle of a multiply
        load_b(8'hFF);
        @(negedge Clk);
        sw  = 8'h7F;
        run = 1'b1;
        @(posedge Clk);
        #1;
        run = 1'b0;
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        check_val("midrst_aval", {24'd0, aval}, 32'd0);
        check_val("midrst_bval", {24'd0, bval}, 32'd0);
        check_val("midrst_x", {31'd0, x}, 32'd0);
        check_val("midrst_busy", {31'd0, busy}, 32'd0);
        check_val("midrst_done", {31'd0, done}, 32'd0);
        $display("mid-multiply reset: aval=%02h bval=%02h x=%0b busy=%0b done=%0b",
                 aval, bval, x, busy, done);
        @(negedge Clk);
        Reset = 1'b0;

        // run held through DONE: no restart, registers stable
        load_b(8'h03);
        mult_and_check("hold", 8'h03, 8'h07, 1'b1, 1'b0);
        held_a = aval;
        held_b = bval;
        repeat (5) @(posedge Clk);
        #1;
        check_val("hold_done", {31'd0, done}, 32'd1);
        check_val("hold_busy", {31'd0, busy}, 32'd0);
        check_val("hold_aval", {24'd0, aval}, {24'd0, held_a});
        check_val("hold_bval", {24'd0, bval}, {24'd0, held_b});
        @(negedge Clk);
        run = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check_val("release_done", {31'd0, done}, 32'd0);
        $display("run released: done=%0b aval=%02h bval=%02h", done, aval, bval);
        // New multiply reuses B (the previous low half) with A and X cleared
        mult_and_check("rerun", held_b, 8'hFE, 1'b0, 1'b0);

        // Random operand pairs
        for (int n = 0; n < 40; n++) begin
            rb = 8'($urandom_range(0, 255));
            rs = 8'($urandom_range(0, 255));
            load_b(rb);
            mult_and_check("rand", rb, rs, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
